// File: rtl/pc_sequencer_pkg.sv
// Shared SPU-lite definitions for the PC sequencer and the branch unit.
// Bit 0 is the MSB on every vector declared with these widths.
package spu_pkg;

    localparam int PC_W        = 32;
    localparam int INSTR_BYTES = 4;
    localparam int FLUSH_W     = 4;
    localparam int BR_COUNT_W  = 16;

    localparam logic [0:PC_W-1] LS_MASK_DEFAULT = 32'h0003_FFFF;

    // Branch-unit PC bus layout: [0:31] target, [32] taken.
    localparam int PCBUS_W          = 33;
    localparam int PCBUS_TARGET_MSB = 0;
    localparam int PCBUS_TARGET_LSB = 31;
    localparam int PCBUS_TAKEN_BIT  = 32;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } pcseq_state_t;

    // Redirect address: confined to local store and forced onto a word boundary.
    function automatic logic [0:PC_W-1] align_target(
        input logic [0:PC_W-1] target,
        input logic [0:PC_W-1] mask
    );
        return target & mask & ~PC_W'(INSTR_BYTES - 1);
    endfunction

    function automatic logic [0:PC_W-1] next_seq_pc(
        input logic [0:PC_W-1] pc,
        input logic [0:PC_W-1] mask
    );
        return (pc + PC_W'(INSTR_BYTES)) & mask;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Branch-resolution, control and fetch-request signals around the PC sequencer.
interface pc_sequencer_if;
    import spu_pkg::*;

    logic                    stall;
    logic                    br_valid;
    logic                    br_taken;
    logic [0:PC_W-1]         br_target;
    logic                    halt;
    logic                    resume;
    logic [0:PC_W-1]         pc;
    logic                    pc_valid;
    logic                    flush;
    logic                    halted;
    logic [0:BR_COUNT_W-1]   br_count;

    modport master (
        input  stall, br_valid, br_taken, br_target, halt, resume,
        output pc, pc_valid, flush, halted, br_count
    );

    modport slave (
        output stall, br_valid, br_taken, br_target, halt, resume,
        input  pc, pc_valid, flush, halted, br_count
    );

endinterface

// File: rtl/pc_sequencer_flush_timer.sv
// Loadable down-counter that times the pipeline flush; done flags the last flush cycle.
module flush_timer
    import spu_pkg::*;
#(
    parameter int W = FLUSH_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] count_r;

    // Count register: load wins over decrement, decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign done  = (count_r == W'(1'b1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC generator: sequential fetch, taken-branch redirect with timed flush, halt/resume.
module pc_sequencer
    import spu_pkg::*;
#(
    parameter logic [0:PC_W-1] RESET_PC     = 32'h0000_0000,
    parameter logic [0:PC_W-1] LS_MASK      = LS_MASK_DEFAULT,
    parameter int              FLUSH_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    pc_sequencer_if.master    bus
);

    localparam logic [0:PC_W-1]    BOOT_PC    = RESET_PC & LS_MASK;
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES);

    pcseq_state_t            state_r, state_s;
    logic [0:PC_W-1]         pc_r, pc_s;
    logic                    pc_valid_r, pc_valid_s;
    logic                    flush_r, flush_s;
    logic                    halted_r, halted_s;
    logic [0:BR_COUNT_W-1]   br_count_r, br_count_s;
    logic                    timer_load_s;
    logic                    timer_dec_s;
    logic                    timer_done_s;
    logic [FLUSH_W-1:0]      timer_count_s;
    logic                    taken_s;

    assign taken_s = bus.br_valid & bus.br_taken;

    flush_timer #(.W(FLUSH_W)) u_flush_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (timer_load_s),
        .load_val (FLUSH_LOAD),
        .dec      (timer_dec_s),
        .count    (timer_count_s),
        .done     (timer_done_s)
    );

    // State, PC and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_BOOT;
            pc_r       <= BOOT_PC;
            pc_valid_r <= 1'b0;
            flush_r    <= 1'b0;
            halted_r   <= 1'b0;
            br_count_r <= '0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            pc_valid_r <= pc_valid_s;
            flush_r    <= flush_s;
            halted_r   <= halted_s;
            br_count_r <= br_count_s;
        end
    end

    // Next-state and next-output decode; pc_valid_r low in RUN marks the first cycle after BOOT.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        pc_valid_s   = pc_valid_r;
        flush_s      = 1'b0;
        halted_s     = 1'b0;
        br_count_s   = br_count_r;
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_s    = ST_RUN;
                pc_s       = BOOT_PC;
                pc_valid_s = 1'b0;
            end
            ST_RUN: begin
                if (taken_s) begin
                    state_s      = ST_FLUSH;
                    pc_s         = align_target(bus.br_target, LS_MASK);
                    pc_valid_s   = 1'b0;
                    flush_s      = 1'b1;
                    br_count_s   = br_count_r + 16'd1;
                    timer_load_s = 1'b1;
                end else if (bus.halt) begin
                    state_s    = ST_HALT;
                    pc_valid_s = 1'b0;
                    halted_s   = 1'b1;
                end else if (pc_valid_r && !bus.stall) begin
                    pc_s       = next_seq_pc(pc_r, LS_MASK);
                    pc_valid_s = 1'b1;
                end else begin
                    pc_valid_s = 1'b1;
                end
            end
            ST_FLUSH: begin
                timer_dec_s = 1'b1;
                if (timer_done_s) begin
                    state_s    = ST_RUN;
                    pc_valid_s = 1'b1;
                end else begin
                    flush_s    = 1'b1;
                    pc_valid_s = 1'b0;
                end
            end
            ST_HALT: begin
                if (bus.resume && !bus.halt) begin
                    state_s    = ST_RUN;
                    pc_valid_s = 1'b1;
                end else begin
                    halted_s   = 1'b1;
                    pc_valid_s = 1'b0;
                end
            end
            default: begin
                state_s    = ST_BOOT;
                pc_s       = BOOT_PC;
                pc_valid_s = 1'b0;
            end
        endcase
    end

    assign bus.pc       = pc_r;
    assign bus.pc_valid = pc_valid_r;
    assign bus.flush    = flush_r;
    assign bus.halted   = halted_r;
    assign bus.br_count = br_count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, redirect/flush, wrap, halt/resume, reset mid-flush.
module tb_pc_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] exp_pc,
                             input logic exp_valid, input logic exp_flush);
        chk({tag, ".pc"},       bus.pc,       exp_pc);
        chk({tag, ".pc_valid"}, 32'(bus.pc_valid), 32'(exp_valid));
        chk({tag, ".flush"},    32'(bus.flush),    32'(exp_flush));
    endtask

    task automatic clear_br;
        bus.br_valid  = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = 32'h0000_0000;
    endtask

    task automatic take_branch(input logic [31:0] target);
        bus.br_valid  = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = target;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.stall  = 1'b0;
        bus.halt   = 1'b0;
        bus.resume = 1'b0;
        clear_br();

        tick();
        tick();
        chk_fetch("reset", 32'h0, 1'b0, 1'b0);
        chk("reset.halted",   32'(bus.halted),   32'h0);
        chk("reset.br_count", 32'(bus.br_count), 32'h0);

        // Boot sequence
        reset = 1'b1;
        tick();
        chk_fetch("boot0", 32'h0, 1'b0, 1'b0);
        tick();
        chk_fetch("boot1", 32'h0, 1'b1, 1'b0);
        tick();
        chk_fetch("seq4", 32'h4, 1'b1, 1'b0);
        tick();
        chk_fetch("seq8", 32'h8, 1'b1, 1'b0);
        tick();
        chk_fetch("seqC", 32'hC, 1'b1, 1'b0);

        // Taken branch with unaligned target
        take_branch(32'h0000_0102);
        tick();
        clear_br();
        chk_fetch("br1.f1", 32'h100, 1'b0, 1'b1);
        chk("br1.count", 32'(bus.br_count), 32'h1);
        tick();
        chk_fetch("br1.f2", 32'h100, 1'b0, 1'b1);
        tick();
        chk_fetch("br1.f3", 32'h100, 1'b0, 1'b1);
        tick();
        chk_fetch("br1.tgt", 32'h100, 1'b1, 1'b0);
        tick();
        chk_fetch("br1.next", 32'h104, 1'b1, 1'b0);
        chk("br1.count2", 32'(bus.br_count), 32'h1);

        // Taken branch with stall and halt together, then a second taken during flush
        take_branch(32'h0000_0200);
        bus.stall = 1'b1;
        bus.halt  = 1'b1;
        tick();
        bus.stall = 1'b0;
        bus.halt  = 1'b0;
        chk_fetch("sim.f1", 32'h200, 1'b0, 1'b1);
        chk("sim.halted", 32'(bus.halted), 32'h0);
        chk("sim.count",  32'(bus.br_count), 32'h2);
        take_branch(32'h0000_0300);
        tick();
        clear_br();
        chk_fetch("sim.f2", 32'h200, 1'b0, 1'b1);
        chk("sim.count2", 32'(bus.br_count), 32'h2);
        tick();
        chk_fetch("sim.f3", 32'h200, 1'b0, 1'b1);
        tick();
        chk_fetch("sim.tgt", 32'h200, 1'b1, 1'b0);
        chk("sim.halted2", 32'(bus.halted), 32'h0);

        // Stall holds the PC with pc_valid asserted
        bus.stall = 1'b1;
        tick();
        chk_fetch("stall1", 32'h200, 1'b1, 1'b0);
        tick();
        chk_fetch("stall2", 32'h200, 1'b1, 1'b0);
        bus.stall = 1'b0;
        tick();
        chk_fetch("unstall", 32'h204, 1'b1, 1'b0);

        // Not-taken branch is a no-op
        bus.br_valid  = 1'b1;
        bus.br_taken  = 1'b0;
        bus.br_target = 32'h0000_0500;
        tick();
        clear_br();
        chk_fetch("ntk", 32'h208, 1'b1, 1'b0);
        chk("ntk.count", 32'(bus.br_count), 32'h2);
        tick();
        chk_fetch("ntk.next", 32'h20C, 1'b1, 1'b0);

        // Out-of-range target is masked and aligned, then the PC wraps at local-store top
        take_branch(32'hFFFF_FFFE);
        tick();
        clear_br();
        chk_fetch("wrap.f1", 32'h3FFFC, 1'b0, 1'b1);
        chk("wrap.count", 32'(bus.br_count), 32'h3);
        tick();
        tick();
        tick();
        chk_fetch("wrap.tgt", 32'h3FFFC, 1'b1, 1'b0);
        tick();
        chk_fetch("wrap.zero", 32'h0, 1'b1, 1'b0);

        // Halt at 0x20, branch ignored while halted, halt+resume stays halted
        for (int i = 0; i < 8; i++) tick();
        chk_fetch("pre_halt", 32'h20, 1'b1, 1'b0);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        chk_fetch("halt", 32'h20, 1'b0, 1'b0);
        chk("halt.halted", 32'(bus.halted), 32'h1);
        take_branch(32'h0000_0400);
        tick();
        clear_br();
        chk_fetch("halt.br", 32'h20, 1'b0, 1'b0);
        chk("halt.br.halted", 32'(bus.halted), 32'h1);
        chk("halt.br.count",  32'(bus.br_count), 32'h3);
        bus.halt   = 1'b1;
        bus.resume = 1'b1;
        tick();
        bus.halt = 1'b0;
        chk("halt.both.halted", 32'(bus.halted), 32'h1);
        chk_fetch("halt.both", 32'h20, 1'b0, 1'b0);
        tick();
        bus.resume = 1'b0;
        chk("resume.halted", 32'(bus.halted), 32'h0);
        chk_fetch("resume", 32'h20, 1'b1, 1'b0);
        tick();
        chk_fetch("resume.next", 32'h24, 1'b1, 1'b0);

        // Asynchronous reset in the second flush cycle
        take_branch(32'h0000_0080);
        tick();
        clear_br();
        chk_fetch("rf.f1", 32'h80, 1'b0, 1'b1);
        tick();
        chk_fetch("rf.f2", 32'h80, 1'b0, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        chk_fetch("rf.async", 32'h0, 1'b0, 1'b0);
        chk("rf.halted", 32'(bus.halted),   32'h0);
        chk("rf.count",  32'(bus.br_count), 32'h0);
        tick();
        chk_fetch("rf.hold", 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk_fetch("rf.boot0", 32'h0, 1'b0, 1'b0);
        tick();
        chk_fetch("rf.boot1", 32'h0, 1'b1, 1'b0);
        tick();
        chk_fetch("rf.seq4", 32'h4, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer and flush controller for the SPU-lite core. It consumes the resolved-branch bus produced by the branch unit (32-bit target plus taken flag) and generates the fetch PC each cycle. On a taken branch it redirects fetch and drives a fixed-length pipeline flush; it also implements halt/resume. It sits between the branch unit's PC output and instruction fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `LS_MASK`, default 32'h0003_FFFF: local-store address mask (256 KB); all PCs are ANDed with it.
- `FLUSH_CYCLES`, default 3: flush length in cycles, legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `stall` input 1: downstream cannot accept a fetch this cycle.
- `br_valid` input 1: branch unit has a resolved branch this cycle.
- `br_taken` input 1: branch taken (the branch unit's PC bus bit 32).
- `br_target` input [0:31]: branch target (the branch unit's PC bus bits 0:31).
- `halt` input 1: stop instruction retired.
- `resume` input 1: restart fetch after halt.
- `pc` output [0:31]: current fetch address.
- `pc_valid` output 1: `pc` is a real fetch request.
- `flush` output 1: kill all in-flight younger instructions.
- `halted` output 1: sequencer is in HALT.
- `br_count` output [0:15]: number of taken redirects, wraps at 16'hFFFF to 0.

## Operation
- Bit 0 is the MSB on all vectors.
- States are BOOT, RUN, FLUSH, HALT.
- BOOT: entered only from reset. It lasts exactly one cycle, then goes to RUN. `pc` = `RESET_PC & LS_MASK`.
- RUN, normal flow:
  - No stall: `pc <= (pc + 4) & LS_MASK`. The mask gives wrap-around at the local-store top.
  - Stall: `pc` holds and `pc_valid` stays 1.
- RUN, taken branch (`br_valid & br_taken`):
  - `pc <= br_target & LS_MASK & ~32'h3`, so the target is word-aligned.
  - Load the flush counter with `FLUSH_CYCLES`, go to FLUSH and increment `br_count`.
- RUN priorities:
  - A taken branch overrides `stall` and `halt` in the same cycle; the halt is dropped.
  - A not-taken `br_valid` has no effect.
- RUN, halt: `halt` without a taken branch goes to HALT. `pc` holds the current value, which is the next instruction.
- FLUSH:
  - `flush` = 1, `pc_valid` = 0, `pc` holds the target, and the counter decrements each cycle.
  - When the counter reaches 1, go to RUN.
  - `br_valid`, `halt` and `stall` are ignored (wrong-path or irrelevant).
- HALT:
  - `pc_valid` = 0, `halted` = 1, and `br_valid` is ignored.
  - `resume` goes to RUN with `pc` unchanged.
  - `halt` and `resume` asserted together keep the block in HALT.
- Reset mid-operation (any state): asynchronous return to BOOT with reset values. An in-progress flush is abandoned.

## Timing
- Reset values:
  - `pc` = `RESET_PC & LS_MASK`
  - `pc_valid` = 0, `flush` = 0, `halted` = 0
  - `br_count` = 0
  - state BOOT, flush counter 0
- All outputs are registered; there are no combinational input-to-output paths.
- BOOT to RUN: `pc_valid` rises on the second rising edge after `reset` deasserts.
- Taken-branch latency, with `br_valid & br_taken` sampled at edge N:
  - After edge N: `pc` = target, `flush` = 1, `pc_valid` = 0, `br_count` has incremented.
  - `flush` stays high for exactly `FLUSH_CYCLES` cycles.
  - After edge N+`FLUSH_CYCLES`: `flush` = 0, `pc_valid` = 1, `pc` = target.
  - The target is presented for at least one cycle before it increments.
- Halt: after the sampling edge, `halted` = 1 and `pc_valid` = 0.
- Resume: after the sampling edge, `halted` = 0 and `pc_valid` = 1.

## Structure
- Package `spu_pkg` holds:
  - the state enum `pcseq_state_t` (BOOT, RUN, FLUSH, HALT);
  - `INSTR_BYTES` = 4;
  - `PC_W` = 32;
  - the default `LS_MASK` constant.
- The branch-unit PC-bus layout is `[0:31]` target, `[32]` taken. It is defined in the package as constants shared with the branch unit.
- Sub-module `flush_timer`: a 4-bit down-counter with load and a `done` output. The FSM, PC register and `br_count` live in `pc_sequencer`.

## Test plan
- Reset then release, no stall:
  - `pc_valid` is 0 for one cycle, then `pc` = 0, 4, 8, 12 on successive cycles.
  - All other outputs are at their reset values while `reset` is low.
- Taken branch from RUN: `br_target` = 32'h0000_0102 with `br_taken` = 1.
  - Next cycle `pc` = 32'h100 and `flush` is high for 3 cycles with `pc_valid` = 0.
  - Then `pc` = 32'h100 valid, then 32'h104; `br_count` = 1.
- Wrap and not-taken:
  - With `pc` = 32'h3FFFC and no stall, next `pc` = 0.
  - `br_valid` = 1 with `br_taken` = 0 leaves the sequence unchanged and `br_count` unchanged.
- Simultaneous events:
  - Taken branch with `stall` = 1 and `halt` = 1 in the same cycle: the redirect happens, HALT is not entered.
  - A second taken branch during FLUSH is ignored; `br_count` increments by 1 only.
- Halt/resume: halt at `pc` = 32'h20.
  - `halted` = 1, `pc` stays 32'h20, `pc_valid` = 0, and `br_valid` is ignored while halted.
  - After `resume`, `pc_valid` = 1 with `pc` = 32'h20, then 32'h24.
- Reset during FLUSH: assert `reset` low in the second flush cycle.
  - `flush` and `pc_valid` drop immediately without a clock edge, and `pc` = `RESET_PC`.
  - The BOOT sequence repeats after release.
